// File: rtl/train_signal_array.sv
// Multi-block three-aspect railway signal controller with hold times,
// ahead-block interlock, force-danger and lamp-test.
//
// Ports:
//   clk, rstn              clock, synchronous active-low reset
//   train[N]               per-block train presence
//   force_danger           treat every block as occupied
//   lamp_test              light every lamp; state untouched
//   green/yellow/red[N]    per-signal aspect, one-hot per channel
//   any_danger             some channel is in DANGER (ignores lamp_test)
module train_signal_array #(
    parameter int N            = 4,
    parameter int DANGER_HOLD  = 2,
    parameter int CAUTION_HOLD = 3,
    parameter int CHAIN        = 1
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic [N-1:0] train,
    input  logic         force_danger,
    input  logic         lamp_test,
    output logic [N-1:0] green,
    output logic [N-1:0] yellow,
    output logic [N-1:0] red,
    output logic         any_danger
);

    localparam int MAXH = (DANGER_HOLD > CAUTION_HOLD) ?
                          DANGER_HOLD : CAUTION_HOLD;
    // One bit minimum so a hold of 1 still has a legal vector.
    localparam int CW   = (MAXH > 1) ? $clog2(MAXH) : 1;

    localparam logic [CW-1:0] DH_LAST = CW'(DANGER_HOLD - 1);
    localparam logic [CW-1:0] CH_LAST = CW'(CAUTION_HOLD - 1);

    typedef enum logic [1:0] {
        CLEAR   = 2'd0,
        CAUTION = 2'd1,
        DANGER  = 2'd2
    } state_e;

    logic [N-1:0] danger_q;
    logic [N-1:0] ahead;

    genvar i;
    generate
        for (i = 0; i < N; i++) begin : g_ch
            state_e        state_q, state_d;
            logic [CW-1:0] cnt_q, cnt_d;
            logic          t;

            // Interlock looks at the registered state of the block ahead,
            // so a chained effect moves back one block per cycle.
            if (i < N - 1) begin : g_ahead
                assign ahead[i] = (CHAIN != 0) && danger_q[i+1];
            end else begin : g_last
                assign ahead[i] = 1'b0;
            end

            assign t = train[i] | force_danger;

            always_comb begin
                state_d = state_q;
                cnt_d   = cnt_q;
                if (t) begin
                    state_d = DANGER;
                    cnt_d   = '0;
                end else begin
                    case (state_q)
                        DANGER: begin
                            if (cnt_q == DH_LAST) begin
                                state_d = CAUTION;
                                cnt_d   = '0;
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        CAUTION: begin
                            // Saturate at the last count while the
                            // block ahead still shows danger.
                            if (cnt_q == CH_LAST) begin
                                if (!ahead[i]) begin
                                    state_d = CLEAR;
                                    cnt_d   = '0;
                                end
                            end else begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                        CLEAR: begin
                            if (ahead[i]) begin
                                state_d = CAUTION;
                                cnt_d   = '0;
                            end
                        end
                        default: begin
                            state_d = CLEAR;
                            cnt_d   = '0;
                        end
                    endcase
                end
            end

            always_ff @(posedge clk) begin
                if (!rstn) begin
                    state_q <= CLEAR;
                    cnt_q   <= '0;
                end else begin
                    state_q <= state_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign danger_q[i] = (state_q == DANGER);
            assign green[i]    = (state_q == CLEAR)   | lamp_test;
            assign yellow[i]   = (state_q == CAUTION) | lamp_test;
            assign red[i]      = (state_q == DANGER)  | lamp_test;
        end
    endgenerate

    assign any_danger = |danger_q;

endmodule

// File: tb/tb_train_signal_array.sv
// Scoreboard bench for train_signal_array: a chained and an unchained
// instance share stimulus and are compared against a reference model.
module tb_train_signal_array;

    localparam int N  = 4;
    localparam int DH = 2;
    localparam int CH = 3;

    logic         clk;
    logic         rstn;
    logic [N-1:0] train;
    logic         force_danger;
    logic         lamp_test;
    logic [N-1:0] green, yellow, red;
    logic         any_danger;
    logic [N-1:0] green0, yellow0, red0;
    logic         any_danger0;

    train_signal_array #(
        .N(N), .DANGER_HOLD(DH), .CAUTION_HOLD(CH), .CHAIN(1)
    ) dut (
        .clk(clk), .rstn(rstn), .train(train),
        .force_danger(force_danger), .lamp_test(lamp_test),
        .green(green), .yellow(yellow), .red(red),
        .any_danger(any_danger)
    );

    train_signal_array #(
        .N(N), .DANGER_HOLD(DH), .CAUTION_HOLD(CH), .CHAIN(0)
    ) dut0 (
        .clk(clk), .rstn(rstn), .train(train),
        .force_danger(force_danger), .lamp_test(lamp_test),
        .green(green0), .yellow(yellow0), .red(red0),
        .any_danger(any_danger0)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [7:0] obs,
                         input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end
    endtask

    typedef struct {
        logic [N-1:0] g, y, r;
        logic         ad;
        logic [N-1:0] g0, y0, r0;
        logic         ad0;
    } exp_t;

    exp_t sbq[$];

    // Reference: [0] = chained, [1] = unchained. 0 clear, 1 caution, 2 danger.
    int mst[2][N];
    int mcn[2][N];

    function automatic void model_step(logic [N-1:0] tr, logic fd,
                                       logic rs);
        int old[2][N];
        old = mst;
        for (int c = 0; c < 2; c++) begin
            for (int k = 0; k < N; k++) begin
                bit t, a;
                t = tr[k] | fd;
                a = (c == 0) && (k < N - 1) && (old[c][(k+1)%N] == 2);
                if (!rs) begin
                    mst[c][k] = 0; mcn[c][k] = 0;
                end else if (t) begin
                    mst[c][k] = 2; mcn[c][k] = 0;
                end else if (old[c][k] == 2) begin
                    if (mcn[c][k] == DH - 1) begin
                        mst[c][k] = 1; mcn[c][k] = 0;
                    end else mcn[c][k]++;
                end else if (old[c][k] == 1) begin
                    if (mcn[c][k] == CH - 1) begin
                        if (!a) begin mst[c][k] = 0; mcn[c][k] = 0; end
                    end else mcn[c][k]++;
                end else if (a) begin
                    mst[c][k] = 1; mcn[c][k] = 0;
                end
            end
        end
    endfunction

    function automatic exp_t model_out(logic lt);
        exp_t e;
        e.g = '0; e.y = '0; e.r = '0; e.ad = 1'b0;
        e.g0 = '0; e.y0 = '0; e.r0 = '0; e.ad0 = 1'b0;
        for (int k = 0; k < N; k++) begin
            e.g[k]  = (mst[0][k] == 0) | lt;
            e.y[k]  = (mst[0][k] == 1) | lt;
            e.r[k]  = (mst[0][k] == 2) | lt;
            e.ad    = e.ad  | (mst[0][k] == 2);
            e.g0[k] = (mst[1][k] == 0) | lt;
            e.y0[k] = (mst[1][k] == 1) | lt;
            e.r0[k] = (mst[1][k] == 2) | lt;
            e.ad0   = e.ad0 | (mst[1][k] == 2);
        end
        return e;
    endfunction

    task automatic step(input logic [N-1:0] tr, input logic fd,
                        input logic lt, input logic rs);
        exp_t e;
        @(negedge clk);
        train        = tr;
        force_danger = fd;
        lamp_test    = lt;
        rstn         = rs;
        model_step(tr, fd, rs);
        sbq.push_back(model_out(lt));
        @(posedge clk);
        #1;
        e = sbq.pop_front();
        check("green",  8'(green),  8'(e.g));
        check("yellow", 8'(yellow), 8'(e.y));
        check("red",    8'(red),    8'(e.r));
        check("any",    8'(any_danger), 8'(e.ad));
        check("green0", 8'(green0), 8'(e.g0));
        check("yellow0",8'(yellow0),8'(e.y0));
        check("red0",   8'(red0),   8'(e.r0));
        check("any0",   8'(any_danger0), 8'(e.ad0));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(4'h0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rstn = 1'b0; train = '0; force_danger = 1'b0; lamp_test = 1'b0;
        for (int c = 0; c < 2; c++)
            for (int k = 0; k < N; k++) begin
                mst[c][k] = 0; mcn[c][k] = 0;
            end

        // Reset with all blocks occupied
        step(4'hF, 1'b0, 1'b0, 1'b0);
        check("rst_green", 8'(green), 8'h0F);
        check("rst_red",   8'(red),   8'h00);
        check("rst_any",   8'(any_danger), 8'h00);

        // Single pass on ch3
        step(4'h8, 1'b0, 1'b0, 1'b1);
        check("arr_red3", 8'(red[3]), 8'h01);
        check("arr_any",  8'(any_danger), 8'h01);
        for (int k = 0; k < 4; k++) step(4'h8, 1'b0, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("dep_red3_k", 8'(red[3]), 8'h01);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("dep_yel3_k1", 8'(yellow[3]), 8'h01);
        check("dep_any_k1",  8'(any_danger), 8'h00);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("dep_yel3_k3", 8'(yellow[3]), 8'h01);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("dep_grn3_k4", 8'(green[3]), 8'h01);
        idle(8);

        // Glitch during danger hold
        step(4'h8, 1'b0, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("gl_red_a", 8'(red[3]), 8'h01);
        step(4'h8, 1'b0, 1'b0, 1'b1);
        check("gl_red_b", 8'(red[3]), 8'h01);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("gl_red_c", 8'(red[3]), 8'h01);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("gl_yel", 8'(yellow[3]), 8'h01);
        idle(10);

        // Chain: train on ch1, ch0 behind it
        step(4'h2, 1'b0, 1'b0, 1'b1);
        check("ch_red1",  8'(red[1]),    8'h01);
        check("ch_grn0",  8'(green[0]),  8'h01);
        step(4'h2, 1'b0, 1'b0, 1'b1);
        check("ch_yel0",  8'(yellow[0]), 8'h01);
        check("ch0_grn0", 8'(green0[0]), 8'h01);
        step(4'h2, 1'b0, 1'b0, 1'b1);
        step(4'h2, 1'b0, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("ch_hold0", 8'(yellow[0]), 8'h01);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("ch_yel1",  8'(yellow[1]), 8'h01);
        check("ch_sat0",  8'(yellow[0]), 8'h01);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("ch_rel0",  8'(green[0]),  8'h01);
        idle(8);

        // force_danger mid-caution on ch2
        step(4'h4, 1'b0, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        step(4'h0, 1'b0, 1'b0, 1'b1);
        check("fd_pre_yel2", 8'(yellow[2]), 8'h01);
        step(4'h0, 1'b1, 1'b0, 1'b1);
        check("fd_red", 8'(red), 8'h0F);
        idle(3);

        // Lamp test while some channels are mid-sequence
        step(4'h0, 1'b0, 1'b1, 1'b1);
        check("lt_green",  8'(green),  8'h0F);
        check("lt_yellow", 8'(yellow), 8'h0F);
        check("lt_red",    8'(red),    8'h0F);
        step(4'h1, 1'b0, 1'b1, 1'b1);
        check("lt_any", 8'(any_danger), 8'h01);
        idle(10);

        // Reset mid-operation
        step(4'h2, 1'b0, 1'b0, 1'b1);
        step(4'h2, 1'b0, 1'b0, 1'b1);
        step(4'h2, 1'b0, 1'b0, 1'b1);
        check("mr_yel0", 8'(yellow[0]), 8'h01);
        step(4'h2, 1'b0, 1'b0, 1'b0);
        check("mr_green", 8'(green), 8'h0F);
        step(4'h2, 1'b0, 1'b0, 1'b1);
        check("mr_red1", 8'(red[1]), 8'h01);

        // Random traffic
        for (int k = 0; k < 200; k++)
            step(4'($urandom_range(0, 15) & $urandom_range(0, 15)),
                 ($urandom_range(0, 31) == 0),
                 ($urandom_range(0, 15) == 0),
                 ($urandom_range(0, 63) != 0));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
